instruction_writer: RTL and testbench
=====================================

INSTRUCTION_WRITER -- requirements
Module: instruction_writer

Interface
REQ-001 Parameter ADDR_W, default 8: instruction-memory address width; depth DEPTH = 2^ADDR_W words.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
REQ-004 start  input  1  begin a new program at address 0.
REQ-005 finish  input  1  end the current program.
REQ-006 inValid  input  1  instruction fields valid.
REQ-007 inReady  output  1  block accepts fields this cycle.
REQ-008 inMode  input  1  0 = register format, 1 = raw/relative-offset word.
REQ-009 inOpcode  input  3  ALU opcode, packed to word bits [11:9].
REQ-010 inSrc1, inSrc2, inDest  input  3 each  register fields, packed to bits [8:6], [5:3], [2:0].
REQ-011 inRaw  input  12  full word, used when inMode=1.
REQ-012 memWe  output  1  instruction-memory write strobe.
REQ-013 memAddr  output  ADDR_W  write address.
REQ-014 memData  output  12  packed instruction word.
REQ-015 wordCount  output  ADDR_W+1  words written in the current program.
REQ-016 busy, full, done  output  1 each  program open; memory full; one-cycle completion pulse.

Function
REQ-017 The block SHALL pack {inOpcode, inSrc1, inSrc2, inDest} when inMode=0, else inRaw, so that the instruction splitter recovers every field unchanged.
REQ-018 FSM states: IDLE, ARMED, WRITE, FULL, DONE.
REQ-019 IDLE: inReady=0, busy=0; start -> ARMED with memAddr=0 and wordCount=0.
REQ-020 ARMED: inReady=1, busy=1; a transfer is inValid&inReady; the packed word is registered into memData and the FSM moves to WRITE.
REQ-021 WRITE: memWe=1 for exactly one cycle with the stable memAddr/memData; inReady=0. On exit, memAddr+1 and wordCount+1.
REQ-022 After WRITE: if wordCount reaches DEPTH -> FULL; else -> ARMED.
REQ-023 Latency: transfer at edge N gives memWe high in cycle N+1. Peak throughput is one word per 2 cycles.
REQ-024 finish is sampled only in ARMED and FULL; it moves the FSM to DONE. In ARMED, a transfer in the same cycle takes priority, and finish is ignored.
REQ-025 DONE: done=1 for one cycle, busy=0; then IDLE. wordCount holds its value until the next start.
REQ-026 FULL: full=1, inReady=0, memWe=0, memAddr wraps to 0; only finish or start leave FULL.
REQ-027 start SHALL be honoured in IDLE, FULL and DONE (restart at address 0) and ignored in ARMED and WRITE. start beats finish when both are asserted.
REQ-028 memAddr arithmetic is modulo DEPTH; wordCount does not wrap (saturates at DEPTH).
REQ-029 No memory write SHALL occur outside WRITE.

Reset
REQ-030 rst_n=0 SHALL force IDLE on the next edge and hold these outputs at 0: inReady, memWe, memAddr, memData, wordCount, busy, full, done.
REQ-031 Reset during WRITE SHALL drop memWe on the next edge; the pending word is discarded.

Structure
REQ-032 A shared header SHALL hold the FSM state encodings, the field bit positions ([11:9], [8:6], [5:3], [2:0]), WORD_W=12 and the default ADDR_W.
REQ-033 Field packing SHALL be a combinational sub-module, instruction_packer; the FSM, counters and output registers stay in instruction_writer.

Verification
REQ-034 Write one word: start, then opcode=3'b101, src1=1, src2=2, dest=3, inMode=0 -> one memWe pulse at addr 0, data 12'hA53, wordCount=1.
REQ-035 Raw mode: inMode=1, inRaw=12'hFFE -> memData 12'hFFE; finish -> done pulses 1 cycle, then IDLE.
REQ-036 Fill with ADDR_W=2: five back-to-back words -> writes at addr 0..3 only, then full=1 and inReady=0. The fifth word is not accepted. finish -> DONE.
REQ-037 Back-pressure: inValid held high continuously -> memWe high on alternate cycles, inReady low during each WRITE cycle.
REQ-038 Reset in WRITE: assert rst_n=0 in the memWe cycle -> next cycle all outputs 0, state IDLE; a later start restarts at addr 0.
REQ-039 Simultaneous events: start with finish in FULL -> restart at addr 0, no done pulse; finish with a transfer in ARMED -> word written, finish ignored.

Source files
------------

// File: rtl/instruction_writer_pkg.sv
// Shared definitions for the instruction writer: word layout, field
// positions, FSM state encodings and the default address width.
package instruction_writer_pkg;

  localparam int WORD_W         = 12;
  localparam int DEFAULT_ADDR_W = 8;

  // Field bit positions inside a packed register-format word
  localparam int OPC_HI  = 11;
  localparam int OPC_LO  = 9;
  localparam int SRC1_HI = 8;
  localparam int SRC1_LO = 6;
  localparam int SRC2_HI = 5;
  localparam int SRC2_LO = 3;
  localparam int DEST_HI = 2;
  localparam int DEST_LO = 0;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_FULL  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/instruction_packer.sv
// Combinational field packer: builds one instruction word either from the
// register-format fields or from the raw word, laid out so the instruction
// splitter recovers every field unchanged.
module instruction_packer
  import instruction_writer_pkg::*;
(
  input  logic              inMode,
  input  logic [2:0]        inOpcode,
  input  logic [2:0]        inSrc1,
  input  logic [2:0]        inSrc2,
  input  logic [2:0]        inDest,
  input  logic [WORD_W-1:0] inRaw,
  output logic [WORD_W-1:0] word
);

  // Select raw word or place each register field at its fixed position
  always_comb begin
    word = '0;
    if (inMode) begin
      word = inRaw;
    end else begin
      word[OPC_HI:OPC_LO]   = inOpcode;
      word[SRC1_HI:SRC1_LO] = inSrc1;
      word[SRC2_HI:SRC2_LO] = inSrc2;
      word[DEST_HI:DEST_LO] = inDest;
    end
  end

endmodule

// File: rtl/instruction_writer.sv
// Instruction writer: accepts instruction fields over a valid/ready
// handshake, packs them and writes them sequentially into an instruction
// memory, one word every two cycles at most, tracking the program length.
module instruction_writer
  import instruction_writer_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              inValid,
  output logic              inReady,
  input  logic              inMode,
  input  logic [2:0]        inOpcode,
  input  logic [2:0]        inSrc1,
  input  logic [2:0]        inSrc2,
  input  logic [2:0]        inDest,
  input  logic [WORD_W-1:0] inRaw,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [WORD_W-1:0] memData,
  output logic [ADDR_W:0]   wordCount,
  output logic              busy,
  output logic              full,
  output logic              done
);

  // Word count value meaning "every memory location used" (DEPTH)
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]        state;
  logic [2:0]        stateNext;
  logic [WORD_W-1:0] packedWord;
  logic              transfer;
  logic              restart;
  logic [ADDR_W:0]   countNext;

  // Count increment that sticks at DEPTH instead of wrapping
  function automatic logic [ADDR_W:0] satInc(input logic [ADDR_W:0] c);
    if (c == FULL_COUNT) return c;
    return c + 1'b1;
  endfunction

  instruction_packer uPacker (
    .inMode   (inMode),
    .inOpcode (inOpcode),
    .inSrc1   (inSrc1),
    .inSrc2   (inSrc2),
    .inDest   (inDest),
    .inRaw    (inRaw),
    .word     (packedWord)
  );

  // Outputs are pure decodes of the state register, so reset clears them
  assign inReady = (state == ST_ARMED);
  assign memWe   = (state == ST_WRITE);
  assign busy    = (state == ST_ARMED) || (state == ST_WRITE) || (state == ST_FULL);
  assign full    = (state == ST_FULL);
  assign done    = (state == ST_DONE);

  assign transfer  = inValid && (state == ST_ARMED);
  assign restart   = start && ((state == ST_IDLE) || (state == ST_FULL) || (state == ST_DONE));
  assign countNext = satInc(wordCount);

  // Next-state selection; a transfer beats finish, start beats finish
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:  if (start) stateNext = ST_ARMED;
      ST_ARMED: begin
        if (inValid)     stateNext = ST_WRITE;
        else if (finish) stateNext = ST_DONE;
      end
      ST_WRITE: stateNext = (countNext == FULL_COUNT) ? ST_FULL : ST_ARMED;
      ST_FULL: begin
        if (start)       stateNext = ST_ARMED;
        else if (finish) stateNext = ST_DONE;
      end
      ST_DONE:  stateNext = start ? ST_ARMED : ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= stateNext;
  end

  // Address and program length advance when a write cycle completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      memAddr   <= '0;
      wordCount <= '0;
    end else if (restart) begin
      memAddr   <= '0;
      wordCount <= '0;
    end else if (state == ST_WRITE) begin
      memAddr   <= memAddr + 1'b1;
      wordCount <= countNext;
    end
  end

  // Capture the packed word on each accepted transfer; held through WRITE
  always_ff @(posedge clk) begin
    if (!rst_n)        memData <= '0;
    else if (transfer) memData <= packedWord;
  end

endmodule

// File: tb/tb_instruction_writer.sv
// Testbench for instruction_writer: directed scenarios followed by a
// randomized run compared against a transaction-level reference model.
module tb_instruction_writer;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n, start, finish, inValid, inMode;
  logic [2:0]    inOpcode, inSrc1, inSrc2, inDest;
  logic [11:0]   inRaw;
  logic          inReady, memWe, busy, full, done;
  logic [AW-1:0] memAddr;
  logic [11:0]   memData;
  logic [AW:0]   wordCount;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          mOpen, mPend, mDone;
  int          mCnt;
  logic [11:0] mWord;

  instruction_writer #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .finish    (finish),
    .inValid   (inValid),
    .inReady   (inReady),
    .inMode    (inMode),
    .inOpcode  (inOpcode),
    .inSrc1    (inSrc1),
    .inSrc2    (inSrc2),
    .inDest    (inDest),
    .inRaw     (inRaw),
    .memWe     (memWe),
    .memAddr   (memAddr),
    .memData   (memData),
    .wordCount (wordCount),
    .busy      (busy),
    .full      (full),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] refPack(input logic mode, input logic [2:0] op,
                                          input logic [2:0] s1, input logic [2:0] s2,
                                          input logic [2:0] d, input logic [11:0] raw);
    int v;
    if (mode) return raw;
    v = int'(op) * 512 + int'(s1) * 64 + int'(s2) * 8 + int'(d);
    return 12'(v);
  endfunction

  task automatic randFields(output logic [11:0] exp);
    inMode   = 1'($urandom_range(0, 1));
    inOpcode = 3'($urandom_range(0, 7));
    inSrc1   = 3'($urandom_range(0, 7));
    inSrc2   = 3'($urandom_range(0, 7));
    inDest   = 3'($urandom_range(0, 7));
    inRaw    = 12'($urandom);
    exp      = refPack(inMode, inOpcode, inSrc1, inSrc2, inDest, inRaw);
  endtask

  // Fill a freshly armed program with DEPTH words, inValid held high
  task automatic fillAll(input string tag);
    logic [11:0] exp;
    logic [11:0] junk;
    for (int i = 0; i < DEPTH; i++) begin
      randFields(exp);
      inValid = 1'b1;
      tick();
      chk({tag, "_we"},    memWe, 1);
      chk({tag, "_rdyW"},  inReady, 0);
      chk({tag, "_addr"},  memAddr, i);
      chk({tag, "_data"},  memData, exp);
      randFields(junk);
      tick();
      chk({tag, "_weOff"}, memWe, 0);
      chk({tag, "_wc"},    wordCount, i + 1);
      chk({tag, "_rdy"},   inReady, (i < DEPTH - 1) ? 1 : 0);
      chk({tag, "_full"},  full, (i == DEPTH - 1) ? 1 : 0);
    end
  endtask

  task automatic modelStep();
    if (mPend) begin
      mPend = 0;
      mCnt  = mCnt + 1;
    end else if (mDone) begin
      mDone = 0;
      if (start) begin mOpen = 1; mCnt = 0; end
    end else if (!mOpen) begin
      if (start) begin mOpen = 1; mCnt = 0; end
    end else if (mCnt == DEPTH) begin
      if (start) mCnt = 0;
      else if (finish) begin mOpen = 0; mDone = 1; end
    end else begin
      if (inValid) begin
        mPend = 1;
        mWord = refPack(inMode, inOpcode, inSrc1, inSrc2, inDest, inRaw);
      end else if (finish) begin
        mOpen = 0; mDone = 1;
      end
    end
  endtask

  initial begin
    logic [11:0] exp;
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; inValid = 1'b0; inMode = 1'b0;
    inOpcode = '0; inSrc1 = '0; inSrc2 = '0; inDest = '0; inRaw = '0;
    tick();
    tick();

    // Reset state
    chk("rst_inReady", inReady, 0);
    chk("rst_memWe", memWe, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_memData", memData, 0);
    chk("rst_wordCount", wordCount, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_done", done, 0);

    // Single register-format word
    rst_n = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("arm_inReady", inReady, 1);
    chk("arm_busy", busy, 1);
    chk("arm_addr", memAddr, 0);
    chk("arm_wc", wordCount, 0);
    inMode = 1'b0; inOpcode = 3'b101; inSrc1 = 3'd1; inSrc2 = 3'd2; inDest = 3'd3;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    chk("w1_we", memWe, 1);
    chk("w1_addr", memAddr, 0);
    chk("w1_data", memData, 12'hA53);
    chk("w1_rdy", inReady, 0);
    tick();
    chk("w1_weOff", memWe, 0);
    chk("w1_wc", wordCount, 1);
    chk("w1_addrNext", memAddr, 1);

    // Raw word, then finish
    inMode = 1'b1; inRaw = 12'hFFE; inValid = 1'b1;
    tick();
    inValid = 1'b0;
    chk("raw_we", memWe, 1);
    chk("raw_data", memData, 12'hFFE);
    chk("raw_addr", memAddr, 1);
    tick();
    chk("raw_wc", wordCount, 2);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 0);
    chk("fin_wc", wordCount, 2);
    tick();
    chk("idle_done", done, 0);
    chk("idle_rdy", inReady, 0);
    chk("idle_busy", busy, 0);
    chk("idle_wcHold", wordCount, 2);

    // Fill memory with inValid held high; extra word refused
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fill_wc0", wordCount, 0);
    fillAll("fill");
    chk("full_addrWrap", memAddr, 0);
    tick();
    chk("fifth_we", memWe, 0);
    chk("fifth_full", full, 1);
    chk("fifth_rdy", inReady, 0);
    chk("fifth_wc", wordCount, DEPTH);
    inValid = 1'b0; finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("fullFin_done", done, 1);
    chk("fullFin_full", full, 0);
    tick();

    // start together with finish while full
    start = 1'b1;
    tick();
    start = 1'b0;
    fillAll("fill2");
    inValid = 1'b0; start = 1'b1; finish = 1'b1;
    tick();
    start = 1'b0; finish = 1'b0;
    chk("sf_done", done, 0);
    chk("sf_rdy", inReady, 1);
    chk("sf_addr", memAddr, 0);
    chk("sf_wc", wordCount, 0);

    // finish together with a transfer in ARMED
    inMode = 1'b1; inRaw = 12'h123; inValid = 1'b1; finish = 1'b1;
    tick();
    inValid = 1'b0; finish = 1'b0;
    chk("tf_we", memWe, 1);
    chk("tf_data", memData, 12'h123);
    chk("tf_done", done, 0);
    tick();
    chk("tf_rdy", inReady, 1);
    chk("tf_busy", busy, 1);
    chk("tf_wc", wordCount, 1);

    // Reset during a write cycle
    inRaw = 12'h456; inValid = 1'b1;
    tick();
    inValid = 1'b0;
    chk("rw_we", memWe, 1);
    chk("rw_addr", memAddr, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rw_weOff", memWe, 0);
    chk("rw_addr0", memAddr, 0);
    chk("rw_data0", memData, 0);
    chk("rw_wc0", wordCount, 0);
    chk("rw_busy", busy, 0);
    chk("rw_rdy", inReady, 0);
    tick();
    chk("rw_idle", inReady, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    inRaw = 12'h007; inValid = 1'b1;
    tick();
    inValid = 1'b0;
    chk("rs_we", memWe, 1);
    chk("rs_addr", memAddr, 0);
    chk("rs_data", memData, 12'h007);
    tick();

    // Randomized run against the reference model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mOpen = 0; mPend = 0; mDone = 0; mCnt = 0; mWord = '0;
    for (int c = 0; c < 400; c++) begin
      randFields(exp);
      inValid = ($urandom_range(0, 1) == 1);
      start   = ($urandom_range(0, 11) == 0);
      finish  = ($urandom_range(0, 7) == 0);
      modelStep();
      tick();
      chk("rnd_memWe", memWe, mPend);
      chk("rnd_inReady", inReady, (mOpen && !mPend && mCnt < DEPTH) ? 1 : 0);
      chk("rnd_busy", busy, mOpen);
      chk("rnd_full", full, (mOpen && !mPend && mCnt == DEPTH) ? 1 : 0);
      chk("rnd_done", done, mDone);
      chk("rnd_wordCount", wordCount, mCnt);
      chk("rnd_memAddr", memAddr, mCnt % DEPTH);
      chk("rnd_memData", memData, mWord);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
